// File: rtl/dpctrl_pkg.sv
// Shared types and constants for the datapath controller.
// DPCTRL_ILLEGAL_TRAP_EN adds the HALT state used to trap illegal encodings.
package dpctrl_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NREG_BITS = 3;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam int unsigned OPC_LSB = 13;
    localparam int unsigned OP_LSB  = 11;
    localparam int unsigned RN_LSB  = 8;
    localparam int unsigned RD_LSB  = 5;
    localparam int unsigned SH_LSB  = 3;
    localparam int unsigned RM_LSB  = 0;

    typedef enum logic [3:0] {
        StWait,
        StDecode,
        StWrImm,
        StGetA,
        StGetB,
        StExec,
        StCmp,
        StWrRd
`ifdef DPCTRL_ILLEGAL_TRAP_EN
        ,
        StHalt
`endif
    } state_e;

    function automatic logic [DATA_W-1:0] sext_imm8(input logic [7:0] imm8);
        return {{(DATA_W - 8){imm8[7]}}, imm8};
    endfunction

endpackage

// File: rtl/dpctrl_if.sv
// Instruction handshake and datapath control bundle between host and controller.
interface dpctrl_if
    import dpctrl_pkg::*;
();
    logic                 s;
    logic                 load;
    logic [DATA_W-1:0]    in;
    logic                 w;
    logic                 err;
    logic [NREG_BITS-1:0] readnum;
    logic [NREG_BITS-1:0] writenum;
    logic                 write;
    logic                 vsel;
    logic                 loada;
    logic                 loadb;
    logic                 asel;
    logic                 bsel;
    logic [1:0]           shift;
    logic [1:0]           ALUop;
    logic                 loadc;
    logic                 loads;
    logic [DATA_W-1:0]    datapath_in;

    modport master (
        output s, load, in,
        input  w, err, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
        input  shift, ALUop, loadc, loads, datapath_in
    );

    modport slave (
        input  s, load, in,
        output w, err, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
        output shift, ALUop, loadc, loads, datapath_in
    );
endinterface

// File: rtl/dpctrl_decode.sv
// Instruction field extraction, imm8 sign extension and legal-encoding classification.
module dpctrl_decode
    import dpctrl_pkg::*;
(
    input  logic [DATA_W-1:0]    ir,
    output logic [1:0]           op,
    output logic [NREG_BITS-1:0] rn,
    output logic [NREG_BITS-1:0] rd,
    output logic [NREG_BITS-1:0] rm,
    output logic [1:0]           sh,
    output logic [DATA_W-1:0]    imm_ext,
    output logic                 legal,
    output logic                 is_mov_imm,
    output logic                 is_mov_reg,
    output logic                 is_alu
);
    logic [2:0] opcode;

    assign opcode  = ir[OPC_LSB +: 3];
    assign op      = ir[OP_LSB +: 2];
    assign rn      = ir[RN_LSB +: NREG_BITS];
    assign rd      = ir[RD_LSB +: NREG_BITS];
    assign sh      = ir[SH_LSB +: 2];
    assign rm      = ir[RM_LSB +: NREG_BITS];
    assign imm_ext = sext_imm8(ir[7:0]);

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign legal      = is_mov_imm || is_mov_reg || is_alu;
endmodule

// File: rtl/datapath_controller.sv
// Instruction register and control FSM sequencing one instruction through the datapath.
// With DPCTRL_ILLEGAL_TRAP_EN an illegal encoding halts until reset; otherwise it is a NOP.
module datapath_controller
    import dpctrl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    dpctrl_if.slave  bus
);
    state_e               state_q, state_d;
    logic [DATA_W-1:0]    ir_q, ir_d;

    logic [1:0]           op, sh;
    logic [NREG_BITS-1:0] rn, rd, rm;
    logic [DATA_W-1:0]    imm_ext;
    logic                 legal, is_mov_imm, is_mov_reg, is_alu;

    logic                 w_q, err_q, write_q, vsel_q, loada_q, loadb_q, asel_q;
    logic                 loadc_q, loads_q;
    logic [NREG_BITS-1:0] readnum_q, writenum_q;
    logic [1:0]           shift_q, aluop_q;
    logic [DATA_W-1:0]    dp_in_q;

    // Decoding ir_d lets the registered outputs see a word captured on the same edge.
    dpctrl_decode u_decode (
        .ir         (ir_d),
        .op         (op),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (sh),
        .imm_ext    (imm_ext),
        .legal      (legal),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_alu     (is_alu)
    );

    always_comb begin
        ir_d    = ir_q;
        state_d = state_q;
        case (state_q)
            StWait: begin
                if (bus.load) ir_d = bus.in;
                if (bus.s) state_d = StDecode;
            end
            StDecode: begin
                if (!legal) begin
`ifdef DPCTRL_ILLEGAL_TRAP_EN
                    state_d = StHalt;
`else
                    state_d = StWait;
`endif
                end else if (is_mov_imm) begin
                    state_d = StWrImm;
                end else if (is_mov_reg || op == ALU_MVN) begin
                    state_d = StGetB;
                end else begin
                    state_d = StGetA;
                end
            end
            StGetA:  state_d = StGetB;
            StGetB:  state_d = (is_alu && op == ALU_SUB) ? StCmp : StExec;
            StExec:  state_d = StWrRd;
            StWrImm: state_d = StWait;
            StCmp:   state_d = StWait;
            StWrRd:  state_d = StWait;
`ifdef DPCTRL_ILLEGAL_TRAP_EN
            StHalt:  state_d = StHalt;
`endif
            default: state_d = StWait;
        endcase
    end

    // Outputs are registered as a function of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StWait;
            ir_q       <= '0;
            w_q        <= 1'b1;
            err_q      <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            vsel_q     <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            asel_q     <= 1'b0;
            shift_q    <= '0;
            aluop_q    <= '0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            dp_in_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            dp_in_q    <= imm_ext;
            w_q        <= 1'b0;
            err_q      <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            vsel_q     <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            asel_q     <= 1'b0;
            shift_q    <= '0;
            aluop_q    <= '0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            case (state_d)
                StWait:   w_q <= 1'b1;
                StDecode: err_q <= !legal;
                StWrImm: begin
                    writenum_q <= rn;
                    vsel_q     <= 1'b1;
                    write_q    <= 1'b1;
                end
                StGetA: begin
                    readnum_q <= rn;
                    loada_q   <= 1'b1;
                end
                StGetB: begin
                    readnum_q <= rm;
                    loadb_q   <= 1'b1;
                end
                StExec: begin
                    shift_q <= sh;
                    loadc_q <= 1'b1;
                    asel_q  <= is_mov_reg;
                    aluop_q <= is_mov_reg ? ALU_ADD : op;
                end
                StCmp: begin
                    shift_q <= sh;
                    aluop_q <= ALU_SUB;
                    loads_q <= 1'b1;
                end
                StWrRd: begin
                    writenum_q <= rd;
                    write_q    <= 1'b1;
                end
`ifdef DPCTRL_ILLEGAL_TRAP_EN
                StHalt:   err_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.w           = w_q;
    assign bus.err         = err_q;
    assign bus.readnum     = readnum_q;
    assign bus.writenum    = writenum_q;
    assign bus.write       = write_q;
    assign bus.vsel        = vsel_q;
    assign bus.loada       = loada_q;
    assign bus.loadb       = loadb_q;
    assign bus.asel        = asel_q;
    assign bus.bsel        = 1'b0;
    assign bus.shift       = shift_q;
    assign bus.ALUop       = aluop_q;
    assign bus.loadc       = loadc_q;
    assign bus.loads       = loads_q;
    assign bus.datapath_in = dp_in_q;
endmodule
